fir_stream_param: RTL and testbench
===================================

// Module: fir_stream_param
// PURPOSE
//  Parametrised streaming FIR for the FAS datapath, successor to the fixed FIR front end.
//  Accepts one sample per data_valid cycle and produces one filtered sample per accepted input.
//  Adds run-time coefficient load, a selectable warm-up mode, round-half-up and saturation with a flag.
//  Output feeds the FFT buffer exactly as the fixed FIR did (fir_valid / fir_d).
// PARAMETERS
//  DIN_W      16  input sample width, signed two's complement
//  DIN_FRAC    8  input fraction bits
//  COEF_W     20  coefficient width, signed
//  COEF_FRAC  16  coefficient fraction bits
//  DOUT_W     16  output width, signed
//  DOUT_FRAC   8  output fraction bits; SHIFT = DIN_FRAC+COEF_FRAC-DOUT_FRAC, must be >= 1
//  TAPS       32  number of taps, 2..64
//  ZERO_FILL   0  0: no output until the delay line is full; 1: output from first sample, history = 0
// PORTS
//  clk         in   1               rising-edge clock
//  rst         in   1               asynchronous reset, active-low
//  data_valid  in   1               data is a valid sample this cycle
//  data        in   DIN_W           input sample x[n]
//  flush       in   1               sync clear of delay line and fill counter
//  coef_wr     in   1               write coef_data to coefficient coef_addr
//  coef_addr   in   clog2(TAPS)     coefficient index; h[0] multiplies the newest sample
//  coef_data   in   COEF_W          coefficient value
//  fir_valid   out  1               fir_d and sat valid this cycle
//  fir_d       out  DOUT_W          y[n] = sum h[k]*x[n-k], rounded and saturated
//  sat         out  1               fir_d was clipped (qualified by fir_valid)
// BEHAVIOUR
//  Reset (rst low, async): fir_valid=0, fir_d=0, sat=0, delay line=0, fill count=0,
//   pipeline valids=0, h[0]=1.0 (1<<COEF_FRAC), h[1..TAPS-1]=0 (identity filter).
//  Accept: sample accepted on a rising edge with data_valid=1; shifts into delay line.
//  Pipeline: S1 registers TAPS products, S2 registers sum+round+saturate.
//   fir_valid asserts exactly 2 cycles after the accepting edge; one pulse per accepted sample.
//   Gaps in data_valid pass through unchanged; no back-pressure, no output stall.
//  Fill control: counter saturates at TAPS. ZERO_FILL=0: sample #k (1-based) produces output only
//   if k >= TAPS, i.e. first TAPS-1 samples are silent. ZERO_FILL=1: every sample produces output.
//  Arithmetic: product DIN_W+COEF_W bits; accumulator DIN_W+COEF_W+clog2(TAPS) bits, no overflow.
//   Round: acc + (1<<(SHIFT-1)), then arithmetic shift right SHIFT (round half toward +inf).
//   Saturate to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]; sat=1 on the same cycle as the clipped fir_d.
//  fir_d and sat hold last value when fir_valid=0.
//  Coefficient write: takes effect on the next edge; a sample accepted on the same edge as
//   coef_wr uses the OLD coefficient set. Samples already in S1/S2 are unaffected.
//  flush: on the edge it is high, delay line and fill counter clear; a data_valid sample on the
//   same edge is discarded; samples already in S1/S2 still emerge. Coefficients kept.
//  rst low mid-stream: in-flight results discarded, no fir_valid after release until new samples.
// TESTING (bench config TAPS=4, other defaults; values hex)
//  1 Reset coefs, ZERO_FILL=0, samples 0100..0600 back-to-back -> three fir_valid pulses,
//    first 2 cycles after sample 4, fir_d=0400,0500,0600, sat=0.
//  2 Load h[0..3]=04000 (0.25), constant 0200 x8 -> five outputs, all 0200; rebuild with
//    ZERO_FILL=1: first four outputs 0080,0100,0180,0200.
//  3 h[0..3]=10000, input 7F00 x4 -> last fir_d=7FFF sat=1; input 8100 x4 -> 8000 sat=1.
//  4 h[0]=08000 only, input 0001 -> 0001; input FFFF -> 0000; input 0003 -> 0002; sat=0.
//  5 data_valid every other cycle, 10 samples, flush after 6th -> output count and timing match
//    accept edges; post-flush outputs restart after 4 new samples.
//  6 rst low for 1 cycle mid-stream -> fir_valid/fir_d/sat=0 at once, h back to identity,
//    no pulse until 4 new samples; coef_wr coincident with a sample uses old h on that sample.

Source files
------------

// File: rtl/fir_stream_param.sv
// rtl/fir_stream_param.sv - parametrised streaming FIR with run-time coefficients, rounding and saturation
//
// Purpose: one filtered output per accepted input sample, y[n] = sum h[k]*x[n-k],
//          rounded half toward +inf and saturated to DOUT_W bits. Results appear two
//          edges after the accepting edge. Coefficients reset to an identity filter.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   data_valid data carries a sample this cycle
//   data       input sample x[n], signed
//   flush      synchronous clear of delay line and fill counter
//   coef_wr    write coef_data into h[coef_addr]
//   coef_addr  coefficient index, h[0] multiplies the newest sample
//   coef_data  coefficient value, signed
//   fir_valid  fir_d/sat valid this cycle
//   fir_d      filtered output, signed
//   sat        fir_d was clipped
module fir_stream_param #(
    parameter int DIN_W     = 16,
    parameter int DIN_FRAC  = 8,
    parameter int COEF_W    = 20,
    parameter int COEF_FRAC = 16,
    parameter int DOUT_W    = 16,
    parameter int DOUT_FRAC = 8,
    parameter int TAPS      = 32,
    parameter int ZERO_FILL = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_valid,
    input  logic [DIN_W-1:0]        data,
    input  logic                    flush,
    input  logic                    coef_wr,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic                    fir_valid,
    output logic [DOUT_W-1:0]       fir_d,
    output logic                    sat
);

    localparam int AW     = $clog2(TAPS);
    localparam int SHIFT  = DIN_FRAC + COEF_FRAC - DOUT_FRAC;
    localparam int PROD_W = DIN_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;
    localparam int FILL_W = $clog2(TAPS + 1);

    localparam logic [FILL_W-1:0]       FILL_FULL = FILL_W'(TAPS);
    localparam logic [FILL_W-1:0]       FILL_LAST = FILL_W'(TAPS - 1);
    localparam logic [AW:0]             TAPS_LIM  = (AW + 1)'(TAPS);
    localparam logic [COEF_W-1:0]       COEF_ONE  = {{(COEF_W-1){1'b0}}, 1'b1} << COEF_FRAC;
    localparam logic signed [ACC_W-1:0] ROUND_C   = {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN   = {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

    logic signed [DIN_W-1:0]  r_dline [TAPS];
    logic signed [COEF_W-1:0] r_coef  [TAPS];
    logic signed [PROD_W-1:0] r_prod  [TAPS];
    logic [FILL_W-1:0]        r_fill;
    logic                     r_cwr;
    logic [AW-1:0]            r_caddr;
    logic [COEF_W-1:0]        r_cdata;
    logic                     r_v0;
    logic                     r_v1;
    logic                     r_fir_valid;
    logic [DOUT_W-1:0]        r_fir_d;
    logic                     r_sat;

    logic                     w_accept;
    logic                     w_emit;
    logic signed [PROD_W-1:0] w_prod [TAPS];
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_shr;
    logic [DOUT_W-1:0]        w_dout;
    logic                     w_clip;

    assign w_accept = data_valid & ~flush;
    // With ZERO_FILL=0 the sample that completes the delay line is the first one to emit.
    assign w_emit   = w_accept & ((ZERO_FILL != 0) | (r_fill >= FILL_LAST));

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            w_prod[k] = PROD_W'(r_dline[k]) * PROD_W'(r_coef[k]);
        end
    end

    always_comb begin
        w_acc = ROUND_C;
        for (int k = 0; k < TAPS; k++) begin
            w_acc = w_acc + {{(ACC_W-PROD_W){r_prod[k][PROD_W-1]}}, r_prod[k]};
        end
        w_shr  = w_acc >>> SHIFT;
        w_clip = 1'b0;
        w_dout = w_shr[DOUT_W-1:0];
        if (w_shr > SAT_MAX) begin
            w_dout = SAT_MAX[DOUT_W-1:0];
            w_clip = 1'b1;
        end else if (w_shr < SAT_MIN) begin
            w_dout = SAT_MIN[DOUT_W-1:0];
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_dline[k] <= '0;
                r_coef[k]  <= (k == 0) ? COEF_ONE : '0;
                r_prod[k]  <= '0;
            end
            r_fill      <= '0;
            r_cwr       <= 1'b0;
            r_caddr     <= '0;
            r_cdata     <= '0;
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_fir_valid <= 1'b0;
            r_fir_d     <= '0;
            r_sat       <= 1'b0;
        end else begin
            // Coefficient writes are committed one edge late, in step with the product
            // stage: a sample accepted alongside a write still multiplies by the old h,
            // the next sample sees the new one.
            r_cwr   <= coef_wr;
            r_caddr <= coef_addr;
            r_cdata <= coef_data;
            if (r_cwr && ({1'b0, r_caddr} < TAPS_LIM)) begin
                r_coef[r_caddr] <= r_cdata;
            end

            if (flush) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_dline[k] <= '0;
                end
                r_fill <= '0;
            end else if (data_valid) begin
                r_dline[0] <= data;
                for (int k = 1; k < TAPS; k++) begin
                    r_dline[k] <= r_dline[k-1];
                end
                if (r_fill != FILL_FULL) begin
                    r_fill <= r_fill + FILL_W'(1);
                end
            end

            r_v0 <= w_emit;
            if (r_v0) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_prod[k] <= w_prod[k];
                end
            end

            r_v1        <= r_v0;
            r_fir_valid <= r_v1;
            if (r_v1) begin
                r_fir_d <= w_dout;
                r_sat   <= w_clip;
            end
        end
    end

    assign fir_valid = r_fir_valid;
    assign fir_d     = r_fir_d;
    assign sat       = r_sat;

endmodule

// File: tb/tb_fir_stream_param.sv
// tb/tb_fir_stream_param.sv - directed bench for fir_stream_param (TAPS=4, ZERO_FILL 0 and 1)
module tb_fir_stream_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_valid;
    logic [15:0] data;
    logic        flush;
    logic        coef_wr;
    logic [1:0]  coef_addr;
    logic [19:0] coef_data;
    logic        fv0, sat0, fv1, sat1;
    logic [15:0] d0, d1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Output records are {sat, fir_d}; c0 holds the cycle index each dut0 pulse was seen.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          c0[$];
    int          acc_q[$];

    always #5 clk = ~clk;

    fir_stream_param #(.TAPS(4), .ZERO_FILL(0)) u_dut0 (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .flush(flush),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .fir_valid(fv0), .fir_d(d0), .sat(sat0)
    );

    fir_stream_param #(.TAPS(4), .ZERO_FILL(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .flush(flush),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .fir_valid(fv1), .fir_d(d1), .sat(sat1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fv0) begin
            q0.push_back({15'd0, sat0, d0});
            c0.push_back(cyc);
        end
        if (fv1) q1.push_back({15'd0, sat1, d1});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic dv, input logic [15:0] d, input logic fl,
                        input logic cw, input logic [1:0] ca, input logic [19:0] cd);
        @(negedge clk);
        data_valid = dv;
        data       = d;
        flush      = fl;
        coef_wr    = cw;
        coef_addr  = ca;
        coef_data  = cd;
        if (dv && !fl) acc_q.push_back(cyc + 1);
    endtask

    task automatic drive(input logic dv, input logic [15:0] d, input logic fl);
        step(dv, d, fl, 1'b0, 2'd0, 20'd0);
    endtask

    task automatic wcoef(input logic [1:0] ca, input logic [19:0] cd);
        step(1'b0, 16'd0, 1'b0, 1'b1, ca, cd);
    endtask

    task automatic quiet(input int n);
        repeat (n) step(1'b0, 16'd0, 1'b0, 1'b0, 2'd0, 20'd0);
    endtask

    task automatic clear_q();
        q0.delete();
        q1.delete();
        c0.delete();
        acc_q.delete();
    endtask

    logic [31:0] exp_zf1 [8] = '{32'h0080, 32'h0100, 32'h0180, 32'h0200,
                                 32'h0200, 32'h0200, 32'h0200, 32'h0200};
    logic [31:0] exp_t5  [4] = '{32'h0400, 32'h0500, 32'h0600, 32'h0A00};
    int          acc_t5  [4] = '{3, 4, 5, 9};

    initial begin
        rst = 1'b0; data_valid = 1'b0; data = '0; flush = 1'b0;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, fv0}, 32'd0);
        check("rst_d",     {16'd0, d0},  32'd0);
        check("rst_sat",   {31'd0, sat0}, 32'd0);
        rst = 1'b1;
        quiet(2);

        // 1: identity coefficients, 0100..0600 back-to-back
        clear_q();
        for (int i = 1; i <= 6; i++) drive(1'b1, 16'(i * 256), 1'b0);
        quiet(5);
        check("t1_count", q0.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("t1_val", (q0.size() > i) ? q0[i] : 32'hDEADBEEF, 32'(16'h0400 + i * 256));
            check("t1_lat", (c0.size() > i) ? c0[i] : -1, acc_q[i+3] + 2);
        end
        check("t1_zf1_count", q1.size(), 6);
        check("t1_zf1_first", (q1.size() > 0) ? q1[0] : 32'hDEADBEEF, 32'h0100);

        // 2: h = 0.25 x4, constant 0200 x8
        drive(1'b0, 16'd0, 1'b1);
        for (int k = 0; k < 4; k++) wcoef(2'(k), 20'h04000);
        quiet(2);
        clear_q();
        repeat (8) drive(1'b1, 16'h0200, 1'b0);
        quiet(5);
        check("t2_count", q0.size(), 5);
        for (int i = 0; i < 5; i++)
            check("t2_val", (q0.size() > i) ? q0[i] : 32'hDEADBEEF, 32'h0200);
        check("t2_zf1_count", q1.size(), 8);
        for (int i = 0; i < 8; i++)
            check("t2_zf1_val", (q1.size() > i) ? q1[i] : 32'hDEADBEEF, exp_zf1[i]);

        // 3: h = 1.0 x4, saturation both ways
        drive(1'b0, 16'd0, 1'b1);
        for (int k = 0; k < 4; k++) wcoef(2'(k), 20'h10000);
        quiet(2);
        clear_q();
        repeat (4) drive(1'b1, 16'h7F00, 1'b0);
        repeat (4) drive(1'b1, 16'h8100, 1'b0);
        quiet(5);
        check("t3_count", q0.size(), 5);
        check("t3_pos_sat", (q0.size() > 0) ? q0[0] : 32'hDEADBEEF, 32'h1_7FFF);
        check("t3_mid",     (q0.size() > 2) ? q0[2] : 32'hDEADBEEF, 32'h0_0000);
        check("t3_neg_sat", (q0.size() > 4) ? q0[4] : 32'hDEADBEEF, 32'h1_8000);

        // 4: h0 = 0.5, rounding half toward +inf
        drive(1'b0, 16'd0, 1'b1);
        wcoef(2'd0, 20'h08000);
        for (int k = 1; k < 4; k++) wcoef(2'(k), 20'h00000);
        quiet(2);
        clear_q();
        repeat (3) drive(1'b1, 16'h0000, 1'b0);
        drive(1'b1, 16'h0001, 1'b0);
        drive(1'b1, 16'hFFFF, 1'b0);
        drive(1'b1, 16'h0003, 1'b0);
        quiet(5);
        check("t4_count", q0.size(), 3);
        check("t4_p1",  (q0.size() > 0) ? q0[0] : 32'hDEADBEEF, 32'h0001);
        check("t4_m1",  (q0.size() > 1) ? q0[1] : 32'hDEADBEEF, 32'h0000);
        check("t4_p3",  (q0.size() > 2) ? q0[2] : 32'hDEADBEEF, 32'h0002);

        // 5: gapped input, flush (with a discarded sample) right after the 6th
        wcoef(2'd0, 20'h10000);
        drive(1'b0, 16'd0, 1'b1);
        quiet(2);
        clear_q();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 16'(i * 256), 1'b0);
            if (i == 6) drive(1'b1, 16'h7700, 1'b1);
            else        drive(1'b0, 16'd0, 1'b0);
        end
        quiet(5);
        check("t5_count", q0.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t5_val", (q0.size() > i) ? q0[i] : 32'hDEADBEEF, exp_t5[i]);
            check("t5_lat", (c0.size() > i) ? c0[i] : -1, acc_q[acc_t5[i]] + 2);
        end
        check("t5_zf1_count", q1.size(), 10);
        check("t5_zf1_restart", (q1.size() > 6) ? q1[6] : 32'hDEADBEEF, 32'h0700);

        // 6: reset mid-stream restores identity h; coef write alongside a sample
        wcoef(2'd0, 20'h04000);
        wcoef(2'd1, 20'h04000);
        drive(1'b0, 16'd0, 1'b1);
        quiet(2);
        clear_q();
        repeat (6) drive(1'b1, 16'h0400, 1'b0);
        @(negedge clk);
        data_valid = 1'b0;
        #1;
        check("t6_pre_valid", {31'd0, fv0}, 32'd1);
        check("t6_pre_d", {16'd0, d0}, 32'h0200);
        #1 rst = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, fv0}, 32'd0);
        check("t6_rst_d", {16'd0, d0}, 32'd0);
        check("t6_rst_sat", {31'd0, sat0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        clear_q();
        quiet(4);
        check("t6_no_stale", q0.size(), 0);
        drive(1'b1, 16'h0100, 1'b0);
        drive(1'b1, 16'h0200, 1'b0);
        drive(1'b1, 16'h0300, 1'b0);
        step(1'b1, 16'h0400, 1'b0, 1'b1, 2'd0, 20'h08000);
        drive(1'b1, 16'h0500, 1'b0);
        quiet(5);
        check("t6_count", q0.size(), 2);
        check("t6_old_h", (q0.size() > 0) ? q0[0] : 32'hDEADBEEF, 32'h0400);
        check("t6_new_h", (q0.size() > 1) ? q0[1] : 32'hDEADBEEF, 32'h0280);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
